// File: rtl/mem_lsu_if.sv
// mem_lsu_if
// Bundles the signals of the load/store unit: the request/response handshake
// toward the execute stage and the word-addressed memory port.
//   req_valid/req_ready   request handshake (transfer when both high)
//   req_we/req_funct3     store flag and RV32I width/sign code
//   req_addr/req_wdata    byte address and store data
//   resp_valid            one-cycle response pulse, no back-pressure
//   resp_rdata/resp_err   extended load data, rejection flag
//   mem_w_enable/r_enable memory write/read strobes
//   mem_addr              word index into the memory
//   mem_data_in/out       memory write data / registered read data
// Modports: slave = the LSU itself, master = the execute stage + memory side.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_w_enable;
    logic        mem_r_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_w_enable, mem_r_enable, mem_addr, mem_data_in
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_w_enable, mem_r_enable, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu
// Load/store unit: takes one byte-addressed RV32I load or store per handshake,
// turns it into word accesses on a memory with two-cycle read latency and no
// byte enables (sub-word stores become read-modify-write), and returns the
// sign/zero-extended load data. Illegal, misaligned and out-of-range requests
// are answered with resp_err without touching memory.
// Ports:
//   clk    clock, all state changes on posedge
//   rst_n  asynchronous active-low reset
//   bus    mem_lsu_if.slave: request/response handshake and memory port
// Parameter:
//   MEM_DEPTH  memory depth in 32-bit words
module mem_lsu #(
    parameter int MEM_DEPTH = 128
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_lsu_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, WR, RESP} state_t;

    localparam logic [29:0] DEPTH_WORDS = 30'(MEM_DEPTH);
    localparam logic [2:0]  F3_B  = 3'b000;
    localparam logic [2:0]  F3_H  = 3'b001;
    localparam logic [2:0]  F3_W  = 3'b010;
    localparam logic [2:0]  F3_BU = 3'b100;
    localparam logic [2:0]  F3_HU = 3'b101;

    state_t      state, state_next;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_in_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        funct_ok, align_ok, req_err, req_is_sw, accept;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data, merged_word;

    // Request legality, decoded straight from the live request fields; it only
    // steers the next state and the registers, never an output directly.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        funct_ok = 1'b0;
        align_ok = 1'b0;
        case (bus.req_funct3)
            F3_B:    begin funct_ok = 1'b1;        align_ok = 1'b1;                        end
            F3_H:    begin funct_ok = 1'b1;        align_ok = !bus.req_addr[0];            end
            F3_W:    begin funct_ok = 1'b1;        align_ok = (bus.req_addr[1:0] == 2'b00); end
            F3_BU:   begin funct_ok = !bus.req_we; align_ok = 1'b1;                        end
            F3_HU:   begin funct_ok = !bus.req_we; align_ok = !bus.req_addr[0];            end
            default: ;
        endcase
        req_err = !(funct_ok && align_ok && (bus.req_addr[31:2] < DEPTH_WORDS));
    end

    assign req_is_sw = bus.req_we && (bus.req_funct3 == F3_W);
    assign accept    = (state == IDLE) && bus.req_valid;

    // NOTE: the asynchronous reset aborts any transfer in flight; sequential state uses <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.req_valid) begin
                if (req_err)        state_next = RESP;
                else if (req_is_sw) state_next = WR;
                else                state_next = RD_A;
            end
            RD_A:    state_next = RD_B;
            RD_B:    state_next = RD_C;
            RD_C:    state_next = we_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane extraction for loads and lane replacement for SB/SH, both working on
    // the word the memory presents while in RD_C.
    always_comb begin
        sel_byte  = bus.mem_data_out[{lane_q, 3'b000} +: 8];
        sel_half  = lane_q[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
        load_data = '0;
        case (funct3_q)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = bus.mem_data_out;
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = '0;
        endcase
        merged_word = bus.mem_data_out;
        if (funct3_q == F3_B) merged_word[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
        else                  merged_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q          <= 1'b0;
            funct3_q      <= '0;
            lane_q        <= '0;
            wdata_q       <= '0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                lane_q   <= bus.req_addr[1:0];
                wdata_q  <= bus.req_wdata[15:0];
                // Rejected requests leave the memory port registers untouched.
                if (!req_err)              mem_addr_q    <= {2'b00, bus.req_addr[31:2]};
                if (!req_err && req_is_sw) mem_data_in_q <= bus.req_wdata;
            end
            if (state == RD_C && we_q) mem_data_in_q <= merged_word;
            // Response data/flag are loaded for the RESP cycle only and read 0 otherwise.
            resp_rdata_q <= (state == RD_C && !we_q) ? load_data : '0;
            resp_err_q   <= accept && req_err;
        end
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.resp_valid   = (state == RESP);
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.mem_r_enable = (state == RD_A);
    assign bus.mem_w_enable = (state == WR);
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data_in  = mem_data_in_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu
// Self-checking bench for mem_lsu: attaches a two-cycle-latency word memory,
// drives directed and random loads/stores, and compares every response with a
// byte-level reference model of RV32I load/store semantics.
`timescale 1ns/1ps
module tb_mem_lsu;
    localparam int MEM_DEPTH = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_lsu_if bus();
    mem_lsu #(.MEM_DEPTH(MEM_DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    // Attached memory: read address registered, data out one edge later;
    // writes are captured in WR and commit on the following edge.
    logic [31:0] mem [0:MEM_DEPTH-1] = '{default: 32'h0};
    logic [31:0] rd_stage = 32'h0;
    logic        wr_pend  = 1'b0;
    logic [6:0]  wr_idx   = 7'h0;
    logic [31:0] wr_word  = 32'h0;
    always @(posedge clk) begin
        if (bus.mem_r_enable) rd_stage <= mem[bus.mem_addr[6:0]];
        bus.mem_data_out <= rd_stage;
        wr_pend <= bus.mem_w_enable;
        wr_idx  <= bus.mem_addr[6:0];
        wr_word <= bus.mem_data_in;
        if (wr_pend) mem[wr_idx] <= wr_word;
    end

    // Handshake and response event counters.
    int acc_cnt  = 0;
    int resp_cnt = 0;
    always @(posedge clk) begin
        if (rst_n && bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
        if (rst_n && bus.resp_valid) resp_cnt <= resp_cnt + 1;
    end

    // Reference model: byte-addressed memory semantics with plain arithmetic.
    logic [31:0] ref_mem [0:MEM_DEPTH-1] = '{default: 32'h0};

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] exp_rdata,
                         output logic exp_err, output int exp_lat);
        bit     legal;
        int     size, sh;
        longint a, word, val, mask;
        a = longint'(addr);
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = 1 << (int'(f3) % 4);
        exp_rdata = 32'h0;
        exp_lat = 1;
        exp_err = !legal || (a % size != 0) || (a / 4 >= MEM_DEPTH);
        if (exp_err) return;
        word = longint'(ref_mem[a / 4]);
        sh   = int'(a % 4) * 8;
        mask = (longint'(1) << (size * 8)) - 1;
        if (!we) begin
            val = (word >> sh) & mask;
            if (f3 < 3'd4 && size < 4 && val > mask / 2) val = val - (mask + 1);
            exp_rdata = val[31:0];
            exp_lat = 4;
        end else begin
            val = (word & ~(mask << sh)) | ((longint'(wdata) & mask) << sh);
            ref_mem[a / 4] = val[31:0];
            exp_lat = (size == 4) ? 2 : 5;
        end
    endtask

    // Drives one request and observes its response; lat counts cycles from the
    // accept cycle (cycle 0) to the resp_valid cycle, -1 if never accepted.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output logic one_cycle,
                         output logic en_seen);
        int guard = 0;
        rdata = 32'h0; err = 1'b0; one_cycle = 1'b0; en_seen = 1'b0;
        @(negedge clk);
        bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
        if (guard >= 20) begin
            bus.req_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            en_seen |= bus.mem_w_enable | bus.mem_r_enable;
            @(negedge clk);
            lat++;
        end
        en_seen |= bus.mem_w_enable | bus.mem_r_enable;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        @(negedge clk);
        one_cycle = !bus.resp_valid;
    endtask

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
    } vec_t;

    task automatic test_reset();
        logic [100:0] obs;
        rst_n = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        obs = {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_w_enable, bus.mem_r_enable,
               bus.resp_rdata, bus.mem_addr, bus.mem_data_in};
        n_cmp++;
        if (obs !== {1'b1, 100'h0}) begin
            n_fail++;
            $display("FAIL reset_held: got %h want %h", obs, {1'b1, 100'h0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        obs = {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_w_enable, bus.mem_r_enable,
               bus.resp_rdata, bus.mem_addr, bus.mem_data_in};
        n_cmp++;
        if (obs !== {1'b1, 100'h0}) begin
            n_fail++;
            $display("FAIL reset_released: got %h want %h", obs, {1'b1, 100'h0});
        end
    endtask

    task automatic test_load_store();
        vec_t tbl [11];
        logic [31:0] rd, mrd;
        logic err, merr, one, en;
        int lat, mlat;
        tbl = '{
            '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 4'd2},
            '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4'd4},
            '{1'b1, 3'd0, 32'h11, 32'h000000AA, 32'h00000000, 1'b0, 4'd5},
            '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADAAEF, 1'b0, 4'd4},
            '{1'b0, 3'd0, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 4'd4},
            '{1'b0, 3'd4, 32'h11, 32'h0,        32'h000000AA, 1'b0, 4'd4},
            '{1'b1, 3'd1, 32'h12, 32'h00001234, 32'h00000000, 1'b0, 4'd5},
            '{1'b0, 3'd2, 32'h10, 32'h0,        32'h1234AAEF, 1'b0, 4'd4},
            '{1'b0, 3'd1, 32'h12, 32'h0,        32'h00001234, 1'b0, 4'd4},
            '{1'b0, 3'd1, 32'h10, 32'h0,        32'hFFFFAAEF, 1'b0, 4'd4},
            '{1'b0, 3'd5, 32'h10, 32'h0,        32'h0000AAEF, 1'b0, 4'd4}
        };
        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, mrd, merr, mlat);
            issue(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, err, lat, one, en);
            n_cmp++;
            if (rd !== tbl[i].rdata) begin
                n_fail++;
                $display("FAIL ls[%0d].rdata: got %h want %h", i, rd, tbl[i].rdata);
            end
            n_cmp++;
            if (err !== tbl[i].err) begin
                n_fail++;
                $display("FAIL ls[%0d].err: got %b want %b", i, err, tbl[i].err);
            end
            n_cmp++;
            if (lat != int'(tbl[i].lat)) begin
                n_fail++;
                $display("FAIL ls[%0d].latency: got %0d want %0d", i, lat, tbl[i].lat);
            end
            n_cmp++;
            if (one !== 1'b1) begin
                n_fail++;
                $display("FAIL ls[%0d].resp_one_cycle: got %b want 1", i, one);
            end
        end
    endtask

    task automatic test_errors();
        vec_t tbl [5];
        logic [31:0] rd, mrd;
        logic err, merr, one, en;
        int lat, mlat;
        tbl = '{
            '{1'b0, 3'd2, 32'h13,  32'h0,        32'h0,        1'b1, 4'd1},
            '{1'b1, 3'd1, 32'h11,  32'h0000FFFF, 32'h0,        1'b1, 4'd1},
            '{1'b0, 3'd2, 32'h200, 32'h0,        32'h0,        1'b1, 4'd1},
            '{1'b0, 3'd3, 32'h10,  32'h0,        32'h0,        1'b1, 4'd1},
            '{1'b0, 3'd2, 32'h10,  32'h0,        32'h1234AAEF, 1'b0, 4'd4}
        };
        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, mrd, merr, mlat);
            issue(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, err, lat, one, en);
            n_cmp++;
            if (rd !== tbl[i].rdata) begin
                n_fail++;
                $display("FAIL err[%0d].rdata: got %h want %h", i, rd, tbl[i].rdata);
            end
            n_cmp++;
            if (err !== tbl[i].err) begin
                n_fail++;
                $display("FAIL err[%0d].err: got %b want %b", i, err, tbl[i].err);
            end
            n_cmp++;
            if (lat != int'(tbl[i].lat)) begin
                n_fail++;
                $display("FAIL err[%0d].latency: got %0d want %0d", i, lat, tbl[i].lat);
            end
            n_cmp++;
            if (en !== !tbl[i].err) begin
                n_fail++;
                $display("FAIL err[%0d].mem_enable_seen: got %b want %b", i, en, !tbl[i].err);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k, acc0, resp0;
        logic ready_seen;
        acc0 = acc_cnt;
        resp0 = resp_cnt;
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b.ready_idle: got %b want 1", bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_funct3 = 3'd5; bus.req_addr = 32'h12;
        k = 1;
        ready_seen = 1'b0;
        while (!bus.resp_valid && k < 20) begin
            ready_seen |= bus.req_ready;
            @(negedge clk);
            k++;
        end
        ready_seen |= bus.req_ready;
        n_cmp++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL b2b.first_latency: got %0d want 4", k);
        end
        n_cmp++;
        if (ready_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b.ready_busy: got %b want 0", ready_seen);
        end
        n_cmp++;
        if (bus.resp_rdata !== 32'h1234AAEF) begin
            n_fail++;
            $display("FAIL b2b.first_rdata: got %h want 1234aaef", bus.resp_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b.ready_after_resp: got %b want 1", bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 1;
        while (!bus.resp_valid && k < 20) begin @(negedge clk); k++; end
        n_cmp++;
        if (k != 4 || bus.resp_rdata !== 32'h00001234) begin
            n_fail++;
            $display("FAIL b2b.second: got lat %0d data %h want lat 4 data 00001234", k, bus.resp_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (acc_cnt - acc0 != 2 || resp_cnt - resp0 != 2) begin
            n_fail++;
            $display("FAIL b2b.counts: got acc %0d resp %0d want 2 2", acc_cnt - acc0, resp_cnt - resp0);
        end
    endtask

    task automatic test_reset_mid();
        logic [100:0] obs;
        logic [31:0] rd;
        logic err, one, en;
        int lat, resp0;
        resp0 = resp_cnt;
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.mem_r_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid.rd_a_enable: got %b want 1", bus.mem_r_enable);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        obs = {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_w_enable, bus.mem_r_enable,
               bus.resp_rdata, bus.mem_addr, bus.mem_data_in};
        n_cmp++;
        if (obs !== {1'b1, 100'h0}) begin
            n_fail++;
            $display("FAIL rstmid.outputs: got %h want %h", obs, {1'b1, 100'h0});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || resp_cnt != resp0) begin
            n_fail++;
            $display("FAIL rstmid.after_release: got ready %b resps %0d want 1 0",
                     bus.req_ready, resp_cnt - resp0);
        end
        issue(1'b0, 3'd2, 32'h10, 32'h0, rd, err, lat, one, en);
        n_cmp++;
        if (rd !== 32'h1234AAEF || err !== 1'b0 || lat != 4) begin
            n_fail++;
            $display("FAIL rstmid.fresh_lw: got %h err %b lat %0d want 1234aaef err 0 lat 4", rd, err, lat);
        end
    endtask

    task automatic test_random();
        logic        we, err, merr, one, en;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rd, mrd;
        int          lat, mlat, sel, size, off;
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (we) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                sel = $urandom_range(0, 4);
                f3 = 3'((sel < 3) ? sel : sel + 1);
            end
            size = 1 << (int'(f3) % 4);
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) off = off & ~(size - 1) & 3;
            sel = $urandom_range(0, 19);
            if (sel == 0)      addr = $urandom();
            else if (sel == 1) addr = 32'($urandom_range(124, 140) * 4 + off);
            else               addr = 32'($urandom_range(0, 15) * 4 + off);
            wdata = $urandom();
            model(we, f3, addr, wdata, mrd, merr, mlat);
            issue(we, f3, addr, wdata, rd, err, lat, one, en);
            n_cmp++;
            if (rd !== mrd || err !== merr || lat != mlat || one !== 1'b1) begin
                n_fail++;
                $display("FAIL rand[%0d] we=%b f3=%0d addr=%h: got %h err %b lat %0d one %b want %h err %b lat %0d one 1",
                         i, we, f3, addr, rd, err, lat, one, mrd, merr, mlat);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_store();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit between the execute stage and the word-addressed data memory. Accepts one byte-addressed RV32I load or store per handshake (LB/LH/LW/LBU/LHU/SB/SH/SW), converts it into word accesses on the memory port, and returns sign- or zero-extended load data. The memory has two-cycle registered read latency and no byte enables, so sub-word stores are done as read-modify-write. Misaligned, out-of-range and illegal requests are rejected without touching memory.

## Interface
- MEM_DEPTH, 128, memory depth in 32-bit words; must match the attached memory SIZE
- clk  in  1  clock, all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bits used for SB/SH
- resp_valid  out  1  one-cycle response pulse; no back-pressure
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid; request rejected
- mem_w_enable  out  1  memory write enable
- mem_r_enable  out  1  memory read enable
- mem_addr  out  32  word index = {2'b00, addr[31:2]}
- mem_data_in  out  32  memory write data
- mem_data_out  in  32  memory read data

## Operation
- States: IDLE, RD_A, RD_B, RD_C, WR, RESP. Reset state IDLE.
- Handshake: transfer when req_valid && req_ready; request fields latched at that edge. Accepting does not depend on resp.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Anything else is illegal.
- Error if illegal funct3, halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= MEM_DEPTH. Error: IDLE -> RESP with resp_err=1, resp_rdata=0, no memory enable asserted.
- IDLE -> RD_A for load/SB/SH; IDLE -> WR for SW.
- RD_A: mem_r_enable=1, mem_addr valid. RD_B, RD_C: mem_w_enable=0, mem_addr held. RD_C samples mem_data_out.
- Load: RD_C -> RESP. Lane select addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend.
- SB/SH: RD_C -> WR with the sampled word, addressed byte/halfword replaced by req_wdata[7:0]/[15:0].
- WR: mem_w_enable=1, mem_data_in = merged word (SB/SH) or req_wdata (SW). WR -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE.
- mem_* and resp_* come from registers/state only; no combinational path from req_* to any output except none (req_ready is state decode).
- Outside RD_A..RD_C and WR: mem_w_enable=0, mem_r_enable=0.

## Timing
- Cycle 0 = accept cycle. resp_valid asserted in: cycle 1 (error), cycle 2 (SW), cycle 4 (load), cycle 5 (SB/SH).
- Memory write commits two edges after WR; earliest following read (RD_A no sooner than cycle after next IDLE) sees the new value.
- Next request accepted no earlier than the cycle after RESP.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_w_enable=0, mem_r_enable=0, mem_addr=0, mem_data_in=0.
- rst_n asserted mid-operation: state -> IDLE and outputs to reset values immediately; no response is produced for the aborted request. A write already sampled by memory in WR may still commit (memory has no reset); bench must not check that word.

## Test plan
- SW 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0; SW resp at cycle 2, LW resp at cycle 4, resp_valid exactly one cycle each.
- SB 0x11 data 0x000000AA onto 0xDEADBEEF -> LW 0x10 = 0xDEADAAEF; LB 0x11 = 0xFFFFFFAA; LBU 0x11 = 0x000000AA; SB resp at cycle 5.
- SH 0x12 data 0x1234 -> LW 0x10 = 0x1234AAEF; LH 0x12 = 0x00001234; LH 0x10 = 0xFFFFAAEF; LHU 0x10 = 0x0000AAEF.
- LW 0x13, SH 0x11, LW 0x200 (word 128, MEM_DEPTH=128), load funct3 011 -> each resp_err=1, resp_rdata=0 at cycle 1, mem_w_enable/mem_r_enable never high; LW 0x10 afterwards still 0x1234AAEF.
- req_valid held high through a load: req_ready=0 in RD_A..RESP; second request accepted in the cycle after RESP, no request lost or duplicated.
- rst_n pulsed low during RD_B of LW 0x10 -> all outputs at reset values while low, no resp_valid; after release req_ready=1 and a fresh LW 0x10 returns 0x1234AAEF at cycle 4.
